// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calc_sequencer block:
//   - operation encodings for the 2-bit op input
//   - FSM state type
//   - iteration count and counter width for the bit-serial mul/div
//   - fixed result returned on divide-by-zero
//   - helper that classifies an op as multi-cycle (bit-serial) or single-cycle
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // One iteration per operand bit.
    localparam int                ITER_CNT  = 4;
    localparam int                CNT_W     = $clog2(ITER_CNT);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(ITER_CNT - 1);

    localparam logic [7:0] DIV0_RESULT = 8'hFF;

    // Multiply and divide run bit-serially; add and subtract finish in one step.
    function automatic logic is_iterative(input logic [1:0] op_v);
        return (op_v == OP_MUL) || (op_v == OP_DIV);
    endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// -----------------------------------------------------------------------------
// calc_iter_unit
// Purely combinational single step of the bit-serial datapath.
//   Multiply: shift-add, LSB of the multiplier first. Step cnt adds
//             (a << cnt) when b[cnt] is set.
//   Divide:   restoring division, MSB of the dividend first. The partial
//             register is {remainder[3:0], quotient[3:0]}, so after the last
//             step it already holds the final result format.
// Ports:
//   is_div_i   1  select restoring-divide step (0 = shift-add step)
//   cnt_i      CNT_W  iteration index 0..ITER_CNT-1
//   a_i        4  latched first operand (multiplicand / dividend)
//   b_i        4  latched second operand (multiplier / divisor)
//   part_i     8  current partial register
//   part_o     8  partial register after this step
// -----------------------------------------------------------------------------
module calc_iter_unit
    import calc_pkg::*;
(
    input  logic             is_div_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [3:0]       a_i,
    input  logic [3:0]       b_i,
    input  logic [7:0]       part_i,
    output logic [7:0]       part_o
);

    logic [CNT_W-1:0] bit_idx;
    logic [4:0]       trial;
    logic [3:0]       rem_new;
    logic [7:0]       mul_addend;

    always_comb begin
        // Division consumes dividend bits from the top down.
        bit_idx    = LAST_ITER - cnt_i;
        // Shift the next dividend bit into the running remainder; one extra
        // bit so the compare against the divisor cannot overflow.
        trial      = {part_i[7:4], a_i[bit_idx]};
        // trial - b is < 16 whenever trial >= b, so the low 4 bits suffice.
        rem_new    = trial[3:0] - b_i;
        mul_addend = b_i[cnt_i] ? ({4'b0000, a_i} << cnt_i) : 8'h00;

        part_o = part_i;
        if (is_div_i) begin
            if (trial >= {1'b0, b_i}) begin
                part_o = {rem_new, part_i[3:0] | (4'b0001 << bit_idx)};
            end else begin
                part_o = {trial[3:0], part_i[3:0]};
            end
        end else begin
            part_o = part_i + mul_addend;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
// Small 4-bit calculator sequenced by an IDLE -> EXEC -> DONE FSM.
// Add/subtract complete after one EXEC cycle; multiply/divide run four EXEC
// cycles through calc_iter_unit. Divide by zero skips EXEC entirely and
// reports 8'hFF with err set.
// Ports:
//   clk     in   1  system clock, rising edge
//   rst     in   1  asynchronous active-high reset
//   start   in   1  request strobe, only honoured in IDLE
//   op      in   2  00 add, 01 sub, 10 div, 11 mul
//   a       in   4  first operand (unsigned)
//   b       in   4  second operand (unsigned)
//   busy    out  1  high whenever the FSM is not in IDLE
//   done    out  1  one-cycle pulse, result/err valid
//   result  out  8  result, held until the next completed operation
//   err     out  1  divide-by-zero flag, held like result
// -----------------------------------------------------------------------------
module calc_sequencer
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       err
);

    state_t           state_q;
    logic [3:0]       a_q;
    logic [3:0]       b_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       part_q;
    logic [7:0]       part_d;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       result_q;
    logic             err_q;

    logic [4:0]       sum_d;
    logic [7:0]       diff_d;

    // Single-cycle results, formed from the latched operands only so input
    // changes after acceptance have no effect.
    assign sum_d  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_d = {4'b0000, a_q} - {4'b0000, b_q};

    calc_iter_unit u_iter (
        .is_div_i (op_q == OP_DIV),
        .cnt_i    (cnt_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .part_i   (part_q),
        .part_o   (part_d)
    );

    // result/err are only written on the transition into DONE, so the
    // partial register never leaks to the outputs while iterating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            part_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        op_q   <= op;
                        cnt_q  <= '0;
                        part_q <= '0;
                        busy_q <= 1'b1;
                        if (op == OP_DIV && b == 4'd0) begin
                            state_q  <= ST_DONE;
                            result_q <= DIV0_RESULT;
                            err_q    <= 1'b1;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= ST_EXEC;
                        end
                    end
                end

                ST_EXEC: begin
                    if (is_iterative(op_q)) begin
                        part_q <= part_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) begin
                            state_q  <= ST_DONE;
                            result_q <= part_d;
                            err_q    <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end else begin
                        state_q  <= ST_DONE;
                        result_q <= (op_q == OP_ADD) ? {3'b000, sum_d} : diff_d;
                        err_q    <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;

endmodule
